// File: rtl/div_radix_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : div_radix_iter                                             |
// | Description : Iterative signed/unsigned integer divider, radix 2^K.      |
// |               Retires BITS_PER_CYCLE quotient bits per CALC cycle by     |
// |               restoring compare-subtract-shift steps and returns         |
// |               quotient and remainder together (RISC-V M semantics:       |
// |               quotient truncates toward zero, remainder takes the sign   |
// |               of the dividend).                                          |
// | Optional    : define DIV_EARLY_OUT_EN to skip the leading-zero digits    |
// |               of |a| (latency (N-lz)/K+1, results unchanged).            |
// | Ports       : clk, reset_n (async, active-low), flush_i (sync abort)     |
// |               req_valid_i/req_ready_o, signed_i, op_a_i, op_b_i          |
// |               rsp_valid_o/rsp_ready_i, quo_o, rem_o (registered)         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module div_radix_iter #(
    parameter int N              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         signed_i,
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [N-1:0] quo_o,
    output logic [N-1:0] rem_o
);

    localparam int ITERS = N / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(ITERS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]   acc;        // partial remainder, always < divisor
    logic [N-1:0]   quo_work;   // dividend bits shift out the top, quotient bits in the bottom
    logic [N-1:0]   div_b;      // |b|
    logic           sign_q;
    logic           sign_r;

    // ------------------------------------------------------------------
    // Operand decode at accept
    // ------------------------------------------------------------------
    logic         sa;
    logic         sb;
    logic [N-1:0] abs_a;
    logic [N-1:0] abs_b;
    logic         b_zero;
    logic         ovf;

    assign sa     = signed_i & op_a_i[N-1];
    assign sb     = signed_i & op_b_i[N-1];
    assign abs_a  = sa ? -op_a_i : op_a_i;
    assign abs_b  = sb ? -op_b_i : op_b_i;
    assign b_zero = (op_b_i == '0);
    assign ovf    = signed_i && (op_a_i == {1'b1, {(N-1){1'b0}}}) && (&op_b_i);

    logic [N-1:0]     start_quo;
    logic [CNT_W-1:0] start_cnt;

`ifdef DIV_EARLY_OUT_EN
    localparam int LZ_W  = $clog2(N) + 1;
    localparam int K_LOG = $clog2(BITS_PER_CYCLE);

    logic [LZ_W-1:0] lz_raw;
    logic [LZ_W-1:0] lz;
    logic [LZ_W-1:0] live_bits;

    // Ascending scan: the last set bit found is the most significant one.
    always_comb begin
        lz_raw = LZ_W'(N);
        for (int i = 0; i < N; i++) begin
            if (abs_a[i]) begin
                lz_raw = LZ_W'(N - 1 - i);
            end
        end
    end

    // Skipped leading zeros must be a whole number of iterations.
    assign lz        = lz_raw & ~LZ_W'(BITS_PER_CYCLE - 1);
    assign live_bits = LZ_W'(N) - lz;
    // Leading zeros would only have shifted zeros into acc and quo, so skip them.
    assign start_quo = abs_a << lz;
    assign start_cnt = CNT_W'(live_bits >> K_LOG);
`else
    assign start_quo = abs_a;
    assign start_cnt = CNT_W'(ITERS);
`endif

    // ------------------------------------------------------------------
    // K restoring steps per cycle; the shifted accumulator needs N+1 bits
    // because 2*acc+1 can exceed N bits before the subtract.
    // ------------------------------------------------------------------
    logic [N:0]   acc_sh;
    logic [N-1:0] acc_nxt;
    logic [N-1:0] quo_nxt;

    always_comb begin
        acc_nxt = acc;
        quo_nxt = quo_work;
        acc_sh  = '0;
        for (int s = 0; s < BITS_PER_CYCLE; s++) begin
            acc_sh  = {acc_nxt, quo_nxt[N-1]};
            quo_nxt = {quo_nxt[N-2:0], 1'b0};
            if (acc_sh >= {1'b0, div_b}) begin
                acc_sh     = acc_sh - {1'b0, div_b};
                quo_nxt[0] = 1'b1;
            end
            acc_nxt = acc_sh[N-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            quo_o       <= '0;
            rem_o       <= '0;
            cnt         <= '0;
            acc         <= '0;
            quo_work    <= '0;
            div_b       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
        end else if (flush_i) begin
            // Abort wins over everything, including an accept this cycle;
            // the last delivered results are left untouched.
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        req_ready_o <= 1'b0;
                        if (b_zero) begin
                            quo_o       <= '1;
                            rem_o       <= op_a_i;
                            rsp_valid_o <= 1'b1;
                            state       <= DONE;
                        end else if (ovf) begin
                            quo_o       <= op_a_i;
                            rem_o       <= '0;
                            rsp_valid_o <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_b    <= abs_b;
                            sign_q   <= sa ^ sb;
                            sign_r   <= sa;
                            acc      <= '0;
                            quo_work <= start_quo;
                            cnt      <= start_cnt;
                            // A zero dividend (early-out build) has no work to do.
                            state    <= (start_cnt == '0) ? FIX : CALC;
                        end
                    end
                end
                CALC: begin
                    acc      <= acc_nxt;
                    quo_work <= quo_nxt;
                    cnt      <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Negating zero yields zero, so a zero result keeps its value.
                    quo_o       <= sign_q ? -quo_work : quo_work;
                    rem_o       <= sign_r ? -acc : acc;
                    rsp_valid_o <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_radix_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_div_radix_iter                                          |
// | Description : Scoreboard bench for div_radix_iter. Instance 0 uses K=1,  |
// |               instance 1 uses K=4. Expected quotient, remainder and      |
// |               latency come from plain integer arithmetic. Honours        |
// |               DIV_EARLY_OUT_EN for the expected latency.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_div_radix_iter;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        sgn_in    [2];
    logic [31:0] op_a      [2];
    logic [31:0] op_b      [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] quo       [2];
    logic [31:0] rem       [2];

    int          ready_mode [2];   // 0: always ready, 1: stalled, 2: random
    exp_t        sb_q [2][$];
    bit          holding [2];
    logic [31:0] cur_q [2];
    logic [31:0] cur_r [2];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    div_radix_iter #(.N(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .signed_i(sgn_in[0]), .op_a_i(op_a[0]), .op_b_i(op_b[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .quo_o(quo[0]), .rem_o(rem[0])
    );

    div_radix_iter #(.N(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .flush_i(flush),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .signed_i(sgn_in[1]), .op_a_i(op_a[1]), .op_b_i(op_b[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .quo_o(quo[1]), .rem_o(rem[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            case (ready_mode[d])
                0:       rsp_ready[d] = 1'b1;
                1:       rsp_ready[d] = 1'b0;
                default: rsp_ready[d] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check32(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, required %h", name, d, act, exp);
        end
    endtask

    // Reference: plain integer division on 64-bit values, truncating toward zero.
    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int k);
        exp_t   e;
        longint la, lb, q, r;
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] ua;
        int          lz;
`endif
        e.acc_cyc = 0;
        if (b == 32'd0) begin
            e.quo = '1; e.rem = a; e.lat = 0;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.quo = a; e.rem = '0; e.lat = 0;
        end else begin
            la = sgn ? longint'($signed(a)) : longint'(a);
            lb = sgn ? longint'($signed(b)) : longint'(b);
            q  = la / lb;
            r  = la % lb;
            e.quo = q[31:0];
            e.rem = r[31:0];
`ifdef DIV_EARLY_OUT_EN
            ua = (sgn && a[31]) ? -a : a;
            lz = 0;
            while (lz < 32 && !ua[31-lz]) lz++;
            lz = lz - (lz % k);
            e.lat = (32 - lz) / k + 1;
`else
            e.lat = 32 / k + 1;
`endif
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n = 0;
        req_valid[d] = 1'b1; sgn_in[d] = sgn; op_a[d] = a; op_b[d] = b;
        @(negedge clk);
        while (!req_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut%0d: req_ready got 0, required 1", d);
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e = model(sgn, a, b, (d == 0) ? 1 : 4);
        e.acc_cyc = cyc;
        sb_q[d].push_back(e);
        req_valid[d] = 1'b0;
        // Scramble operands: the divider must not re-read them.
        op_a[d] = $urandom; op_b[d] = $urandom; sgn_in[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int d);
        int n = 0;
        while ((sb_q[d].size() != 0 || rsp_valid[d]) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (sb_q[d].size() != 0 || rsp_valid[d]) begin
            checks++; errors++;
            $display("FAIL drain_timeout dut%0d: pending %0d responses, required 0", d, sb_q[d].size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops an expectation on each new response, then watches it stay stable.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                holding[d] = 1'b0;
            end else if (rsp_valid[d]) begin
                if (!holding[d]) begin
                    if (sb_q[d].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp dut%0d: got quo=%h rem=%h, required no response", d, quo[d], rem[d]);
                    end else begin
                        e = sb_q[d].pop_front();
                        check32("quo", d, quo[d], e.quo);
                        check32("rem", d, rem[d], e.rem);
                        check32("latency", d, cyc - e.acc_cyc, e.lat);
                    end
                    cur_q[d] = quo[d];
                    cur_r[d] = rem[d];
                end else begin
                    check32("hold_quo", d, quo[d], cur_q[d]);
                    check32("hold_rem", d, rem[d], cur_r[d]);
                    check32("hold_req_ready", d, 32'(req_ready[d]), 32'd0);
                end
                holding[d] = !rsp_ready[d];
            end else begin
                holding[d] = 1'b0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; sgn_in[d] = 1'b0; op_a[d] = '0; op_b[d] = '0; ready_mode[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check32("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
            check32("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            check32("rst_quo", d, quo[d], 32'd0);
            check32("rst_rem", d, rem[d], 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases, K=1
        issue(0, 1'b0, 32'd100, 32'd7);
        issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        issue(0, 1'b0, 32'h0000_1234, 32'd0);
        issue(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 1'b0, 32'd5, 32'd3);
        issue(0, 1'b1, 32'd0, 32'd5);
        issue(0, 1'b1, 32'h8000_0000, 32'd1);
        drain(0);

        // Consumer stalls the response for 5 cycles
        ready_mode[0] = 1;
        issue(0, 1'b0, 32'd1000, 32'd9);
        n = 0;
        while (!rsp_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check32("stall_rsp_arrives", 0, 32'(rsp_valid[0]), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check32("stall_rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
            check32("stall_req_ready", 0, 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk); #1;
        ready_mode[0] = 0;
        drain(0);

        // Asynchronous reset in the middle of CALC
        issue(0, 1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check32("midrst_req_ready", 0, 32'(req_ready[0]), 32'd1);
        check32("midrst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        check32("midrst_quo", 0, quo[0], 32'd0);
        check32("midrst_rem", 0, rem[0], 32'd0);
        void'(sb_q[0].pop_back());
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Flush mid-CALC, then a flush that coincides with a request
        issue(0, 1'b1, 32'hFFFF_0000, 32'd77);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(sb_q[0].pop_back());
        @(negedge clk);
        check32("flush_req_ready", 0, 32'(req_ready[0]), 32'd1);
        check32("flush_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; sgn_in[0] = 1'b0; op_a[0] = 32'd50; op_b[0] = 32'd5;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check32("flush_discard_accept", 0, 32'(req_ready[0]), 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // Random traffic, K=1, random consumer backpressure
        ready_mode[0] = 2;
        repeat (150) issue(0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
        drain(0);
        ready_mode[0] = 0;

        // K=4: two back-to-back ops, then random traffic
        issue(1, 1'b0, 32'd100, 32'd7);
        issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        drain(1);
        ready_mode[1] = 2;
        repeat (150) issue(1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
        drain(1);
        ready_mode[1] = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
